// File: rtl/credit_tx.sv
// credit_tx: transmit end of a credit-based link, feeding a remote FIFO of depth CREDITS
//   clk, rstn (async, active-low)
//   in_valid/in_ready/in_data : local producer stream
//   tx_valid/tx_data          : registered link output, no backpressure
//   crd_ret                   : credits returned by the receiver this cycle
//   credits/outstanding       : credits held locally / beats owed by the remote side
//   idle                      : all credits home and output register empty
//   overflow                  : sticky, more credits returned than issued
module credit_tx #(
  parameter int  DATA_WIDTH = 1,
  parameter type TYPE       = logic [DATA_WIDTH-1:0],
  parameter int  CREDITS    = 4,
  parameter int  CW         = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  TYPE           in_data,
  output logic          tx_valid,
  output TYPE           tx_data,
  input  logic [CW-1:0] crd_ret,
  output logic [CW-1:0] credits,
  output logic [CW-1:0] outstanding,
  output logic          idle,
  output logic          overflow
);
  if (CREDITS < 1) begin : g_bad_credits
    $fatal(1, "credit_tx: CREDITS must be >= 1");
  end
  logic          fire;
  logic [CW:0]   sum;
  logic          sat;
  assign in_ready    = credits != '0;
  assign fire        = in_valid && in_ready;
  // one extra bit so a surplus return is seen before it wraps the counter
  assign sum         = {1'b0, credits} - {{CW{1'b0}}, fire} + {1'b0, crd_ret};
  assign sat         = sum > (CW + 1)'(CREDITS);
  assign outstanding = CW'(CREDITS) - credits;
  assign idle        = (credits == CW'(CREDITS)) && !tx_valid;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credits  <= CW'(CREDITS);
      tx_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      credits  <= sat ? CW'(CREDITS) : sum[CW-1:0];
      tx_valid <= fire;
      overflow <= overflow | sat;
    end
  end
  always_ff @(posedge clk) begin
    if (fire) tx_data <= in_data;
  end
endmodule

// File: tb/tb_credit_tx.sv
// tb_credit_tx: directed table plus corner sequences and a receiver-model soak for credit_tx
module tb_credit_tx;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [2:0] crd_ret = '0;
  logic [2:0] credits;
  logic [2:0] outstanding;
  logic       idle;
  logic       overflow;
  int checks = 0;
  int errors = 0;
  credit_tx #(.DATA_WIDTH(8), .CREDITS(4)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .crd_ret(crd_ret), .credits(credits), .outstanding(outstanding),
    .idle(idle), .overflow(overflow)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic [2:0] cr;
    logic       tv;
    logic [7:0] td;
    logic [2:0] crd;
    logic       rdy;
    logic       ov;
  } vec_t;
  vec_t v[15];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_state(input string tag, input logic tv, input logic [2:0] crd, input logic rdy, input logic ov);
    chk({tag, " tx_valid"}, int'(tx_valid), int'(tv));
    chk({tag, " credits"}, int'(credits), int'(crd));
    chk({tag, " outstanding"}, int'(outstanding), 4 - int'(crd));
    chk({tag, " in_ready"}, int'(in_ready), int'(rdy));
    chk({tag, " overflow"}, int'(overflow), int'(ov));
    chk({tag, " idle"}, int'(idle), int'(crd == 3'd4 && !tv));
  endtask
  initial begin
    int n;
    int cyc;
    int ret;
    logic [7:0] sb[$];
    logic [7:0] remote[$];
    int due[$];
    logic [7:0] exp_d;
    v[0]  = '{1'b1, 8'h11, 3'd0, 1'b1, 8'h11, 3'd3, 1'b1, 1'b0};
    v[1]  = '{1'b1, 8'h22, 3'd0, 1'b1, 8'h22, 3'd2, 1'b1, 1'b0};
    v[2]  = '{1'b1, 8'h33, 3'd0, 1'b1, 8'h33, 3'd1, 1'b1, 1'b0};
    v[3]  = '{1'b1, 8'h44, 3'd0, 1'b1, 8'h44, 3'd0, 1'b0, 1'b0};
    v[4]  = '{1'b1, 8'h55, 3'd0, 1'b0, 8'h44, 3'd0, 1'b0, 1'b0};
    v[5]  = '{1'b1, 8'h55, 3'd2, 1'b0, 8'h44, 3'd2, 1'b1, 1'b0};
    v[6]  = '{1'b1, 8'h55, 3'd0, 1'b1, 8'h55, 3'd1, 1'b1, 1'b0};
    v[7]  = '{1'b1, 8'h66, 3'd0, 1'b1, 8'h66, 3'd0, 1'b0, 1'b0};
    v[8]  = '{1'b0, 8'h77, 3'd1, 1'b0, 8'h66, 3'd1, 1'b1, 1'b0};
    v[9]  = '{1'b1, 8'h77, 3'd1, 1'b1, 8'h77, 3'd1, 1'b1, 1'b0};
    v[10] = '{1'b1, 8'h88, 3'd0, 1'b1, 8'h88, 3'd0, 1'b0, 1'b0};
    v[11] = '{1'b0, 8'h00, 3'd4, 1'b0, 8'h88, 3'd4, 1'b1, 1'b0};
    v[12] = '{1'b0, 8'h00, 3'd1, 1'b0, 8'h88, 3'd4, 1'b1, 1'b1};
    v[13] = '{1'b1, 8'h99, 3'd0, 1'b1, 8'h99, 3'd3, 1'b1, 1'b1};
    v[14] = '{1'b0, 8'h00, 3'd1, 1'b0, 8'h99, 3'd4, 1'b1, 1'b1};
    #12;
    chk_state("reset", 1'b0, 3'd4, 1'b1, 1'b0);
    rstn = 1'b1;
    step();
    chk_state("idle", 1'b0, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      in_valid = v[i].iv;
      in_data  = v[i].d;
      crd_ret  = v[i].cr;
      step();
      chk_state($sformatf("vec%0d", i), v[i].tv, v[i].crd, v[i].rdy, v[i].ov);
      chk($sformatf("vec%0d tx_data", i), int'(tx_data), int'(v[i].td));
    end
    crd_ret  = 3'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hC0 + 8'(i);
      step();
    end
    chk_state("pre_reset", 1'b1, 3'd1, 1'b1, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk_state("async_reset", 1'b0, 3'd4, 1'b1, 1'b0);
    #1 rstn = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'hD0 + 8'(i);
      step();
      if (tx_valid) n++;
    end
    chk("post_reset beats", n, 4);
    chk_state("post_reset stall", 1'b0, 3'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    crd_ret  = 3'd4;
    step();
    crd_ret = 3'd0;
    chk_state("refill", 1'b0, 3'd4, 1'b1, 1'b0);
    for (cyc = 0; cyc < 2000; cyc++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      ret = 0;
      for (int i = due.size() - 1; i >= 0; i--) begin
        if (due[i] == cyc) begin
          ret++;
          due.delete(i);
        end
      end
      crd_ret = 3'(ret);
      if (in_valid && in_ready) sb.push_back(in_data);
      step();
      if (tx_valid) begin
        remote.push_back(tx_data);
        if (remote.size() > 4) chk("remote fifo depth", remote.size(), 4);
      end
      if (remote.size() > 0 && $urandom_range(0, 1) == 1) begin
        if (sb.size() == 0) begin
          chk("scoreboard underrun", 0, 1);
        end else begin
          exp_d = sb.pop_front();
          chk("soak data", int'(remote.pop_front()), int'(exp_d));
        end
        due.push_back(cyc + 1 + int'($urandom_range(0, 3)));
      end
    end
    in_valid = 1'b0;
    n = 0;
    while ((remote.size() > 0 || due.size() > 0) && n < 200) begin
      ret = 0;
      for (int i = due.size() - 1; i >= 0; i--) begin
        if (due[i] == cyc) begin
          ret++;
          due.delete(i);
        end
      end
      crd_ret = 3'(ret);
      step();
      if (tx_valid) remote.push_back(tx_data);
      if (remote.size() > 0) begin
        if (sb.size() > 0) begin
          exp_d = sb.pop_front();
          chk("drain data", int'(remote.pop_front()), int'(exp_d));
        end else begin
          void'(remote.pop_front());
          chk("drain scoreboard", 0, 1);
        end
        due.push_back(cyc + 1);
      end
      cyc++;
      n++;
    end
    crd_ret = 3'd0;
    step();
    chk("drain bounded", int'(n < 200), 1);
    chk("scoreboard empty", sb.size(), 0);
    chk_state("soak end", 1'b0, 3'd4, 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
